// File: rtl/ucsbece154a_defines.sv
// Shared register-file widths, the x0 constant and the write-back queue entry type.
package ucsbece154a_defines;

  localparam int REG_W   = 32;
  localparam int REG_A_W = 5;
  localparam logic [REG_A_W-1:0] X0 = 5'd0;

  typedef struct packed {
    logic [REG_A_W-1:0] rd;
    logic [REG_W-1:0]   data;
  } wbq_entry_t;

endpackage

// File: rtl/ucsbece154a_wbq_match.sv
// Newest-to-oldest search of the write-back queue for a register address.
// The data output only exists when UCSBECE154A_WBQ_FWD_EN is defined.
module ucsbece154a_wbq_match
  import ucsbece154a_defines::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic [REG_A_W-1:0] rds   [DEPTH],
`ifdef UCSBECE154A_WBQ_FWD_EN
  input  logic [REG_W-1:0]   datas [DEPTH],
`endif
  input  logic [DEPTH-1:0]   valid,
  input  logic [PTR_W-1:0]   tail,
  input  logic [REG_A_W-1:0] addr,
`ifdef UCSBECE154A_WBQ_FWD_EN
  output logic [REG_W-1:0]   data,
`endif
  output logic               hit
);

  logic [PTR_W-1:0] idx;

  // Walk back from tail-1; the first valid match is the newest pending write.
  always_comb begin
    hit = 1'b0;
    idx = '0;
`ifdef UCSBECE154A_WBQ_FWD_EN
    data = '0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      idx = tail - PTR_W'(1) - PTR_W'(k);
      if (!hit && valid[idx] && (rds[idx] == addr) && (addr != X0)) begin
        hit = 1'b1;
`ifdef UCSBECE154A_WBQ_FWD_EN
        data = datas[idx];
`endif
      end
    end
  end

endmodule

// File: rtl/ucsbece154a_rf_wbq.sv
// Write-back queue owning the RF write port, with read-side forwarding or stall.
// UCSBECE154A_WBQ_FWD_EN selects forwarding; otherwise reads of pending registers raise stall_o.
module ucsbece154a_rf_wbq
  import ucsbece154a_defines::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enq_valid_i,
  output logic               enq_ready_o,
  input  logic [REG_A_W-1:0] enq_rd_i,
  input  logic [REG_W-1:0]   enq_data_i,
  input  logic               drain_en_i,
  output logic               rf_we3_o,
  output logic [REG_A_W-1:0] rf_a3_o,
  output logic [REG_W-1:0]   rf_wd3_o,
  input  logic [REG_A_W-1:0] a1_i,
  input  logic [REG_A_W-1:0] a2_i,
  input  logic [REG_W-1:0]   rf_rd1_i,
  input  logic [REG_W-1:0]   rf_rd2_i,
  output logic [REG_W-1:0]   rd1_o,
  output logic [REG_W-1:0]   rd2_o,
  output logic               stall_o,
  output logic [PTR_W:0]     count_o
);

  wbq_entry_t         entry_q [DEPTH];
  logic [DEPTH-1:0]   valid_q;
  logic [PTR_W-1:0]   head_q, tail_q;
  logic [PTR_W:0]     count_q;

  logic               full, empty;
  logic               enq_fire, enq_store, deq;
  logic [REG_A_W-1:0] rds [DEPTH];
  logic               hit1, hit2;

  assign full      = (count_q == (PTR_W+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign enq_fire  = enq_valid_i && !full;
  // x0 writes complete the handshake but never occupy an entry.
  assign enq_store = enq_fire && (enq_rd_i != X0);
  assign deq       = !empty && drain_en_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      if (enq_store) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PTR_W'(1);
      end
      if (deq) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PTR_W'(1);
      end
      case ({enq_store, deq})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (enq_store) entry_q[tail_q] <= '{rd: enq_rd_i, data: enq_data_i};
  end

  assign enq_ready_o = !full;
  assign count_o     = count_q;
  assign rf_we3_o    = deq;
  assign rf_a3_o     = empty ? X0 : entry_q[head_q].rd;
  assign rf_wd3_o    = empty ? '0 : entry_q[head_q].data;

  always_comb begin
    for (int k = 0; k < DEPTH; k++) rds[k] = entry_q[k].rd;
  end

`ifdef UCSBECE154A_WBQ_FWD_EN
  logic [REG_W-1:0] datas [DEPTH];
  logic [REG_W-1:0] fwd1, fwd2;

  always_comb begin
    for (int k = 0; k < DEPTH; k++) datas[k] = entry_q[k].data;
  end
`endif

  ucsbece154a_wbq_match #(.DEPTH(DEPTH)) u_match1 (
    .rds   (rds),
`ifdef UCSBECE154A_WBQ_FWD_EN
    .datas (datas),
`endif
    .valid (valid_q),
    .tail  (tail_q),
    .addr  (a1_i),
`ifdef UCSBECE154A_WBQ_FWD_EN
    .data  (fwd1),
`endif
    .hit   (hit1)
  );

  ucsbece154a_wbq_match #(.DEPTH(DEPTH)) u_match2 (
    .rds   (rds),
`ifdef UCSBECE154A_WBQ_FWD_EN
    .datas (datas),
`endif
    .valid (valid_q),
    .tail  (tail_q),
    .addr  (a2_i),
`ifdef UCSBECE154A_WBQ_FWD_EN
    .data  (fwd2),
`endif
    .hit   (hit2)
  );

`ifdef UCSBECE154A_WBQ_FWD_EN
  assign rd1_o   = (a1_i == X0) ? '0 : (hit1 ? fwd1 : rf_rd1_i);
  assign rd2_o   = (a2_i == X0) ? '0 : (hit2 ? fwd2 : rf_rd2_i);
  assign stall_o = 1'b0;
`else
  // The head entry still counts as pending in its drain cycle; the RF only holds it from the next cycle.
  assign rd1_o   = (a1_i == X0) ? '0 : rf_rd1_i;
  assign rd2_o   = (a2_i == X0) ? '0 : rf_rd2_i;
  assign stall_o = hit1 || hit2;
`endif

endmodule

// File: tb/tb_ucsbece154a_rf_wbq.sv
// Randomised and directed bench for ucsbece154a_rf_wbq against a queue-based model
// that also keeps an architectural register file fed by the DUT's drain port.
module tb_ucsbece154a_rf_wbq;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        enq_valid_i, enq_ready_o;
  logic [4:0]  enq_rd_i;
  logic [31:0] enq_data_i;
  logic        drain_en_i;
  logic        rf_we3_o;
  logic [4:0]  rf_a3_o;
  logic [31:0] rf_wd3_o;
  logic [4:0]  a1_i, a2_i;
  logic [31:0] rf_rd1_i, rf_rd2_i, rd1_o, rd2_o;
  logic        stall_o;
  logic [2:0]  count_o;

  always #5 clk = ~clk;

  ucsbece154a_rf_wbq #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .enq_valid_i(enq_valid_i), .enq_ready_o(enq_ready_o),
    .enq_rd_i(enq_rd_i), .enq_data_i(enq_data_i),
    .drain_en_i(drain_en_i),
    .rf_we3_o(rf_we3_o), .rf_a3_o(rf_a3_o), .rf_wd3_o(rf_wd3_o),
    .a1_i(a1_i), .a2_i(a2_i),
    .rf_rd1_i(rf_rd1_i), .rf_rd2_i(rf_rd2_i),
    .rd1_o(rd1_o), .rd2_o(rd2_o),
    .stall_o(stall_o), .count_o(count_o)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  logic [31:0] rf [32];
  int          n_chk = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected corrected read data; hit reports a pending write to a nonzero register.
  function automatic logic [31:0] exp_rd(input logic [4:0] a, input logic [31:0] raw,
                                         output logic hit);
    logic [31:0] r;
    hit = 1'b0;
    r   = raw;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (!hit && q[i].rd == a) begin
        hit = 1'b1;
        r   = q[i].data;
      end
    end
    if (a == 5'd0) begin
      hit = 1'b0;
      return 32'd0;
    end
`ifdef UCSBECE154A_WBQ_FWD_EN
    return r;
`else
    return raw;
`endif
  endfunction

  // One cycle: drive at the falling edge, check 1ns later, advance the model at the rising edge.
  task automatic step(input logic v, input logic [4:0] rd, input logic [31:0] d,
                      input logic dr, input logic [4:0] ra1, input logic [4:0] ra2,
                      input logic rst);
    logic        e_we, acc, h1, h2;
    logic [31:0] e1, e2;
    int          sz;
    enq_valid_i = v;
    enq_rd_i    = rd;
    enq_data_i  = d;
    drain_en_i  = dr;
    a1_i        = ra1;
    a2_i        = ra2;
    reset       = rst;
    rf_rd1_i    = rf[ra1];
    rf_rd2_i    = rf[ra2];
    #1;
    sz   = q.size();
    e_we = (sz > 0) && dr;
    acc  = v && (sz < DEPTH);
    e1   = exp_rd(ra1, rf[ra1], h1);
    e2   = exp_rd(ra2, rf[ra2], h2);
    check("count", 32'(count_o), 32'(sz));
    check("enq_ready", 32'(enq_ready_o), 32'(sz < DEPTH));
    check("rf_we3", 32'(rf_we3_o), 32'(e_we));
    check("rf_a3", 32'(rf_a3_o), (sz > 0) ? 32'(q[0].rd) : 32'd0);
    check("rf_wd3", rf_wd3_o, (sz > 0) ? q[0].data : 32'd0);
    check("rd1", rd1_o, e1);
    check("rd2", rd2_o, e2);
`ifdef UCSBECE154A_WBQ_FWD_EN
    check("stall", 32'(stall_o), 32'd0);
`else
    check("stall", 32'(stall_o), 32'(h1 || h2));
`endif
    @(posedge clk);
    if (rst) begin
      q.delete();
    end else begin
      if (e_we) begin
        rf[q[0].rd] = q[0].data;
        void'(q.pop_front());
      end
      if (acc && rd != 5'd0) q.push_back('{rd: rd, data: d});
    end
    @(negedge clk);
  endtask

  task automatic enq(input logic [4:0] rd, input logic [31:0] d);
    step(1'b1, rd, d, 1'b0, 5'd0, 5'd0, 1'b0);
  endtask

  initial begin
    rf[0] = 32'd0;
    for (int i = 1; i < 32; i++) rf[i] = $urandom;
    reset = 1'b1; enq_valid_i = 1'b0; enq_rd_i = '0; enq_data_i = '0;
    drain_en_i = 1'b0; a1_i = '0; a2_i = '0; rf_rd1_i = '0; rf_rd2_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset with three pending writes; none may reach the RF afterwards.
    enq(5'd1, 32'hA1); enq(5'd2, 32'hA2); enq(5'd3, 32'hA3);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd1, 5'd2, 1'b1);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd1, 5'd3, 1'b0);

    // Same register written twice: newest value wins.
    enq(5'd5, 32'h11); enq(5'd5, 32'h22); enq(5'd6, 32'h33);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd5, 5'd6, 1'b0);
    check("three_count", 32'(count_o), 32'd3);

    // Fill, refuse a fifth write, then drain in FIFO order.
    enq(5'd8, 32'h44);
    enq_valid_i = 1'b1; #1;
    check("full_ready", 32'(enq_ready_o), 32'd0);
    step(1'b1, 5'd9, 32'h55, 1'b0, 5'd9, 5'd8, 1'b0);
    step(1'b1, 5'd9, 32'h56, 1'b1, 5'd5, 5'd9, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd8, 1'b0);
    check("drained_we3", 32'(rf_we3_o), 32'd0);
    check("rf_x5", rf[5], 32'h22);

    // x0 write is accepted but not stored.
    step(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 5'd0, 1'b0);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0, 1'b0);

    // Steady occupancy of two across the pointer wrap.
    enq(5'd10, 32'h100); enq(5'd11, 32'h101);
    for (int i = 0; i < 10; i++)
      step(1'b1, 5'(12 + i), 32'h200 + 32'(i), 1'b1, 5'(11 + i), 5'(10 + i), 1'b0);
    check("wrap_count", 32'(count_o), 32'd2);
    for (int i = 0; i < 3; i++) step(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 5'd21, 1'b0);

    // Pending x7: stall (or forward) until the drain commits it.
    enq(5'd7, 32'h77);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd7, 5'd0, 1'b0);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd0, 1'b0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd7, 5'd0, 1'b0);

    // Random traffic over a small register range to provoke collisions.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
           1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), 1'($urandom_range(0, 63) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
